// File: rtl/ysyx_23060191_csr_ctrl_pkg.sv
// Shared definitions for the CSR/trap sequencer: datapath widths, the
// supported machine-mode CSR addresses, decode op encodings and the
// sequencer state encoding.
package ysyx_23060191_csr_ctrl_pkg;

    localparam int CPU_WIDTH_DEF  = 32;
    localparam int CSR_ADDR_W_DEF = 12;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } csr_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR    = 3'd2,
        S_EPC   = 3'd3,
        S_CAUSE = 3'd4,
        S_JMP   = 3'd5
    } csr_state_e;

    function automatic logic csr_addr_ok(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/ysyx_23060191_csr_alu.sv
// Write-data generator for the Zicsr read-modify-write ops.
//   i_op        : latched op (only CSRRW/CSRRS/CSRRC produce a write)
//   i_old       : CSR value captured in the read cycle
//   i_rs1       : rs1 operand
//   i_rs1_is_x0 : rs1 field is x0
//   o_wdata     : value to write back to the CSR
//   o_no_write  : suppress the write (set/clear with x0, or not a CSR op)
module ysyx_23060191_csr_alu
    import ysyx_23060191_csr_ctrl_pkg::*;
#(
    parameter int W = CPU_WIDTH_DEF
) (
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_old,
    input  logic [W-1:0] i_rs1,
    input  logic         i_rs1_is_x0,
    output logic [W-1:0] o_wdata,
    output logic         o_no_write
);

    always_comb begin
        o_wdata    = '0;
        o_no_write = 1'b1;
        case (i_op)
            OP_CSRRW: begin
                o_wdata    = i_rs1;
                o_no_write = 1'b0;
            end
            // Set/clear with x0 is a pure read: no side effect on the CSR.
            OP_CSRRS: begin
                o_wdata    = i_old | i_rs1;
                o_no_write = i_rs1_is_x0;
            end
            OP_CSRRC: begin
                o_wdata    = i_old & ~i_rs1;
                o_no_write = i_rs1_is_x0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060191_csr_ctrl.sv
// Multi-cycle CSR/trap sequencer feeding the CSR register file.
//   clk, rst           : clock, synchronous active-high reset
//   i_valid / o_ready  : instruction handshake from decode (ready in IDLE only)
//   i_op, i_pc, i_rs1_data, i_rs1_is_x0, i_csr_addr, i_ecall_no : instruction fields
//   o_addr_rd_csr / i_data_rd_csr : combinational CSR read port
//   i_mtvec, i_mepc    : current trap vector / exception PC
//   o_wr_en_csr, o_addr_wr_csr, o_data_wr_csr : CSR write port
//   o_rd_wen, o_rd_data : rd writeback of the old CSR value
//   o_redirect, o_redirect_pc : PC redirect for ECALL/MRET
//   o_illegal          : CSR op addressed an unsupported CSR
//   o_done             : one-cycle retire pulse
//
// state | meaning
// IDLE  | waiting for an instruction, o_ready=1
// RD    | present latched address on the read port, capture old value
// WR    | write back RMW result, return old value to rd, retire
// EPC   | ECALL: mepc <= pc
// CAUSE | ECALL: mcause <= a5
// JMP   | redirect to mtvec (ECALL) or mepc (MRET), retire
module ysyx_23060191_csr_ctrl
    import ysyx_23060191_csr_ctrl_pkg::*;
#(
    parameter int CPU_WIDTH  = CPU_WIDTH_DEF,
    parameter int CSR_ADDR_W = CSR_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [CPU_WIDTH-1:0]  i_pc,
    input  logic [CPU_WIDTH-1:0]  i_rs1_data,
    input  logic                  i_rs1_is_x0,
    input  logic [CSR_ADDR_W-1:0] i_csr_addr,
    input  logic [CPU_WIDTH-1:0]  i_ecall_no,
    output logic [CSR_ADDR_W-1:0] o_addr_rd_csr,
    input  logic [CPU_WIDTH-1:0]  i_data_rd_csr,
    input  logic [CPU_WIDTH-1:0]  i_mtvec,
    input  logic [CPU_WIDTH-1:0]  i_mepc,
    output logic                  o_wr_en_csr,
    output logic [CSR_ADDR_W-1:0] o_addr_wr_csr,
    output logic [CPU_WIDTH-1:0]  o_data_wr_csr,
    output logic                  o_rd_wen,
    output logic [CPU_WIDTH-1:0]  o_rd_data,
    output logic                  o_redirect,
    output logic [CPU_WIDTH-1:0]  o_redirect_pc,
    output logic                  o_illegal,
    output logic                  o_done
);

    csr_state_e            state_q, state_d;
    csr_op_e               op_q, op_d;
    logic [CPU_WIDTH-1:0]  pc_q, pc_d;
    logic [CPU_WIDTH-1:0]  rs1_q, rs1_d;
    logic                  x0_q, x0_d;
    logic [CSR_ADDR_W-1:0] addr_q, addr_d;
    logic [CPU_WIDTH-1:0]  eno_q, eno_d;
    logic [CPU_WIDTH-1:0]  old_q, old_d;

    logic [CPU_WIDTH-1:0]  alu_wdata;
    logic                  alu_no_write;
    logic                  live;

    ysyx_23060191_csr_alu #(.W(CPU_WIDTH)) u_alu (
        .i_op        (op_q),
        .i_old       (old_q),
        .i_rs1       (rs1_q),
        .i_rs1_is_x0 (x0_q),
        .o_wdata     (alu_wdata),
        .o_no_write  (alu_no_write)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        x0_d    = x0_q;
        addr_d  = addr_q;
        eno_d   = eno_q;
        old_d   = old_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    case (i_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_RD;
                        OP_ECALL:                     state_d = S_EPC;
                        OP_MRET:                      state_d = S_JMP;
                        default:                      state_d = S_IDLE;
                    endcase
                    if (state_d != S_IDLE) begin
                        op_d   = csr_op_e'(i_op);
                        pc_d   = i_pc;
                        rs1_d  = i_rs1_data;
                        x0_d   = i_rs1_is_x0;
                        addr_d = i_csr_addr;
                        eno_d  = i_ecall_no;
                    end
                end
            end
            S_RD: begin
                old_d   = i_data_rd_csr;
                state_d = S_WR;
            end
            S_WR:    state_d = S_IDLE;
            S_EPC:   state_d = S_CAUSE;
            S_CAUSE: state_d = S_JMP;
            S_JMP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
            pc_q    <= '0;
            rs1_q   <= '0;
            x0_q    <= 1'b0;
            addr_q  <= '0;
            eno_q   <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            x0_q    <= x0_d;
            addr_q  <= addr_d;
            eno_q   <= eno_d;
            old_q   <= old_d;
        end
    end

    // Strobes are masked while rst is high so that a reset raised in the
    // middle of a sequence cannot commit the write/redirect of that cycle.
    assign live      = ~rst;
    assign o_rd_data = old_q;

    always_comb begin
        o_ready       = (state_q == S_IDLE);
        o_addr_rd_csr = CSR_MTVEC;
        o_wr_en_csr   = 1'b0;
        o_addr_wr_csr = '0;
        o_data_wr_csr = '0;
        o_rd_wen      = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        o_illegal     = 1'b0;
        o_done        = 1'b0;
        case (state_q)
            S_RD: o_addr_rd_csr = addr_q;
            S_WR: begin
                o_addr_wr_csr = addr_q;
                o_data_wr_csr = alu_wdata;
                o_done        = live;
                if (csr_addr_ok(addr_q)) begin
                    o_wr_en_csr = live & ~alu_no_write;
                    o_rd_wen    = live;
                end else begin
                    o_illegal   = live;
                end
            end
            S_EPC: begin
                o_wr_en_csr   = live;
                o_addr_wr_csr = CSR_MEPC;
                o_data_wr_csr = pc_q;
            end
            S_CAUSE: begin
                o_wr_en_csr   = live;
                o_addr_wr_csr = CSR_MCAUSE;
                o_data_wr_csr = eno_q;
            end
            S_JMP: begin
                o_redirect    = live;
                o_redirect_pc = (op_q == OP_ECALL) ? i_mtvec : i_mepc;
                o_done        = live;
            end
            default: ;
        endcase
    end

endmodule
